// File: rtl/morse_key_sequencer.sv
// morse_key_sequencer: conditions the raw Morse key, classifies each press as
// dot/dash, strobes the symbol shift datapath and hands completed letters to
// the decoder over a valid/ack handshake.
// Optional word-space detection is compiled in when MORSE_WORD_GAP_EN is defined.
module morse_key_sequencer #(
    parameter int CNT_W          = 26,
    parameter int DEBOUNCE_CYC   = 4,
    parameter int DOT_MAX_CYC    = 20,
    parameter int LETTER_GAP_CYC = 40,
    parameter int MAX_SYMS       = 5,
    parameter int WORD_GAP_CYC   = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_in,
    output logic       sym_valid,
    output logic       sym_bit,
    output logic       shift_clr,
    output logic       letter_valid,
    output logic [2:0] letter_len,
    output logic       letter_err,
    input  logic       letter_ack,
    output logic       word_space
);
    localparam int                DB_W       = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [DB_W-1:0]   DB_LAST    = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  DOT_MAX    = CNT_W'(DOT_MAX_CYC);
    localparam logic [CNT_W-1:0]  LETTER_GAP = CNT_W'(LETTER_GAP_CYC);
    localparam logic [2:0]        SYM_LIMIT  = 3'(MAX_SYMS);

    typedef enum logic [1:0] {IDLE, PRESS, GAP, HOLD} state_t;

    logic             sync_reg, key_s_reg, key_db_reg, key_db_d_reg;
    logic [DB_W-1:0]  db_cnt_reg;
    state_t           state_reg, state_next;
    logic [CNT_W-1:0] press_len_reg, press_len_next;
    logic [CNT_W-1:0] gap_cnt_reg, gap_cnt_next;
    logic [2:0]       sym_cnt_reg, sym_cnt_next;
    logic             ovf_reg, ovf_next;
    logic             sym_valid_reg, sym_valid_next;
    logic             sym_bit_reg, sym_bit_next;
    logic             clr_reg, clr_next;
    logic             key_rise, key_fall;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    // Synchroniser and debouncer. The key path resets to "pressed" so that a key
    // held through reset looks already down and cannot produce a rising edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg     <= 1'b1;
            key_s_reg    <= 1'b1;
            key_db_reg   <= 1'b1;
            key_db_d_reg <= 1'b1;
            db_cnt_reg   <= '0;
        end else begin
            sync_reg     <= key_in;
            key_s_reg    <= sync_reg;
            key_db_d_reg <= key_db_reg;
            if (key_s_reg == key_db_reg) begin
                db_cnt_reg <= '0;
            end else if (db_cnt_reg == DB_LAST) begin
                key_db_reg <= key_s_reg;
                db_cnt_reg <= '0;
            end else begin
                db_cnt_reg <= db_cnt_reg + 1'b1;
            end
        end
    end

    assign key_rise = key_db_reg & ~key_db_d_reg;
    assign key_fall = ~key_db_reg & key_db_d_reg;

    // State register plus press/gap timers, symbol count and strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            press_len_reg <= '0;
            gap_cnt_reg   <= '0;
            sym_cnt_reg   <= '0;
            ovf_reg       <= 1'b0;
            sym_valid_reg <= 1'b0;
            sym_bit_reg   <= 1'b0;
            clr_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            press_len_reg <= press_len_next;
            gap_cnt_reg   <= gap_cnt_next;
            sym_cnt_reg   <= sym_cnt_next;
            ovf_reg       <= ovf_next;
            sym_valid_reg <= sym_valid_next;
            sym_bit_reg   <= sym_bit_next;
            clr_reg       <= clr_next;
        end
    end

    // Next-state and datapath control for the press/gap/hold sequence.
    always_comb begin
        state_next     = state_reg;
        press_len_next = press_len_reg;
        gap_cnt_next   = gap_cnt_reg;
        sym_cnt_next   = sym_cnt_reg;
        ovf_next       = ovf_reg;
        sym_valid_next = 1'b0;
        sym_bit_next   = 1'b0;
        clr_next       = 1'b0;
        unique case (state_reg)
            IDLE: begin
`ifdef MORSE_WORD_GAP_EN
                gap_cnt_next = sat_inc(gap_cnt_reg);
`endif
                if (key_rise) begin
                    press_len_next = CNT_W'(1);
                    state_next     = PRESS;
                end
            end
            PRESS: begin
                press_len_next = sat_inc(press_len_reg);
                if (key_fall) begin
                    state_next   = GAP;
                    gap_cnt_next = '0;
                    if (sym_cnt_reg < SYM_LIMIT) begin
                        sym_valid_next = 1'b1;
                        sym_bit_next   = (press_len_reg > DOT_MAX);
                        sym_cnt_next   = sym_cnt_reg + 1'b1;
                    end else begin
                        ovf_next = 1'b1;
                    end
                end
            end
            GAP: begin
                gap_cnt_next = sat_inc(gap_cnt_reg);
                if (key_rise) begin
                    press_len_next = CNT_W'(1);
                    state_next     = PRESS;
                end else if (gap_cnt_reg == LETTER_GAP) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
`ifdef MORSE_WORD_GAP_EN
                gap_cnt_next = sat_inc(gap_cnt_reg);
`endif
                if (letter_ack) begin
                    state_next   = IDLE;
                    clr_next     = 1'b1;
                    sym_cnt_next = '0;
                    ovf_next     = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign sym_valid    = sym_valid_reg & ~rst;
    assign sym_bit      = sym_bit_reg & ~rst;
    assign shift_clr    = clr_reg | rst;
    assign letter_valid = (state_reg == HOLD) & ~rst;
    assign letter_len   = letter_valid ? sym_cnt_reg : 3'd0;
    assign letter_err   = letter_valid & ovf_reg;

`ifdef MORSE_WORD_GAP_EN
    localparam logic [CNT_W-1:0] WORD_GAP = CNT_W'(WORD_GAP_CYC);

    logic word_armed_reg, word_armed_next;
    logic word_fired_reg, word_fired_next;

    // A word space needs an acked letter since the last one, fires once per
    // gap, and only from IDLE so an unacked letter delays it until after ack.
    assign word_space = ~rst & word_armed_reg & ~word_fired_reg &
                        (state_reg == IDLE) & (gap_cnt_reg >= WORD_GAP);

    // Arm on letter ack, disarm on pulse, re-open the gap on each key release.
    always_comb begin
        word_armed_next = word_armed_reg;
        word_fired_next = word_fired_reg;
        if (word_space) begin
            word_armed_next = 1'b0;
            word_fired_next = 1'b1;
        end
        if (state_reg == HOLD && letter_ack) begin
            word_armed_next = 1'b1;
        end
        if (state_reg == PRESS && key_fall) begin
            word_fired_next = 1'b0;
        end
    end

    // Word-gap bookkeeping registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_armed_reg <= 1'b0;
            word_fired_reg <= 1'b0;
        end else begin
            word_armed_reg <= word_armed_next;
            word_fired_reg <= word_fired_next;
        end
    end
`else
    // Word gaps are not tracked in this build.
    assign word_space = 1'b0;
`endif

endmodule

// File: tb/tb_morse_key_sequencer.sv
// tb_morse_key_sequencer: directed self-checking bench for morse_key_sequencer.
// Word-space checks follow the MORSE_WORD_GAP_EN build setting.
module tb_morse_key_sequencer;
    logic       clk = 1'b0;
    logic       rst;
    logic       key_in;
    logic       letter_ack;
    logic       sym_valid, sym_bit, shift_clr, letter_valid, letter_err, word_space;
    logic [2:0] letter_len;

    int checks = 0;
    int errors = 0;
    int sv_cnt = 0;
    int both_cnt = 0;
    int ws_cnt = 0;
    logic bits_q[$];
    int base;
    int qbase;
    int wbase;

    always #5 clk = ~clk;

    morse_key_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .key_in       (key_in),
        .sym_valid    (sym_valid),
        .sym_bit      (sym_bit),
        .shift_clr    (shift_clr),
        .letter_valid (letter_valid),
        .letter_len   (letter_len),
        .letter_err   (letter_err),
        .letter_ack   (letter_ack),
        .word_space   (word_space)
    );

    // Observe strobes mid-cycle.
    always @(negedge clk) begin
        if (sym_valid === 1'b1) begin
            sv_cnt <= sv_cnt + 1;
            bits_q.push_back(sym_bit);
        end
        if (sym_valid === 1'b1 && shift_clr === 1'b1) both_cnt <= both_cnt + 1;
        if (word_space === 1'b1) ws_cnt <= ws_cnt + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic press(input int len, input int gap);
        $display("press: key high %0d cycles then low %0d cycles", len, gap);
        key_in = 1'b1;
        repeat (len) tick();
        key_in = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic wait_letter(input string tag);
        int n = 0;
        while (letter_valid !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, letter_valid}, 32'd1);
    endtask

    task automatic ack_letter(input string tag);
        $display("ack: letter_len=%0d letter_err=%0d", letter_len, letter_err);
        letter_ack = 1'b1;
        tick();
        letter_ack = 1'b0;
        chk({tag, "_clr"}, {31'd0, shift_clr}, 32'd1);
        chk({tag, "_valid_drop"}, {31'd0, letter_valid}, 32'd0);
        tick();
        chk({tag, "_clr_end"}, {31'd0, shift_clr}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        key_in = 1'b0;
        letter_ack = 1'b0;

        // Power-on reset
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_shift_clr", {31'd0, shift_clr}, 32'd1);
            chk("rst_outputs", {24'd0, sym_valid, sym_bit, letter_valid, letter_len, letter_err, word_space}, 32'd0);
        end
        rst = 1'b0;
        tick();
        chk("post_rst_clr", {31'd0, shift_clr}, 32'd0);
        repeat (10) tick();

        // Letter A: dot at the boundary (20), dash just past it (21)
        base = sv_cnt;
        press(20, 15);
        chk("dot_count", sv_cnt - base, 32'd1);
        chk("dot_bit", {31'd0, bits_q[bits_q.size() - 1]}, 32'd0);
        press(21, 15);
        chk("dash_count", sv_cnt - base, 32'd2);
        chk("dash_bit", {31'd0, bits_q[bits_q.size() - 1]}, 32'd1);
        chk("no_early_letter", {31'd0, letter_valid}, 32'd0);
        wait_letter("A_valid");
        chk("A_len", {29'd0, letter_len}, 32'd2);
        chk("A_err", {31'd0, letter_err}, 32'd0);
        ack_letter("A_ack");

        // Six presses: five symbols kept, overflow flagged
        base = sv_cnt;
        qbase = bits_q.size();
        for (int i = 0; i < 6; i++) press((i % 2 == 1) ? 25 : 8, 10);
        wait_letter("ovf_valid");
        chk("ovf_count", sv_cnt - base, 32'd5);
        for (int k = 0; k < 5; k++)
            chk("ovf_bit", {31'd0, bits_q[qbase + k]}, (k % 2 == 1) ? 32'd1 : 32'd0);
        chk("ovf_len", {29'd0, letter_len}, 32'd5);
        chk("ovf_err", {31'd0, letter_err}, 32'd1);

        // Hold 50 cycles unacked with key activity
        for (int i = 0; i < 50; i++) begin
            key_in = ((i % 16) < 8);
            tick();
            chk("hold_stable", {27'd0, letter_valid, letter_len, letter_err}, 32'h1B);
        end
        key_in = 1'b0;
        repeat (10) tick();
        chk("hold_no_strobe", sv_cnt - base, 32'd5);
        chk("hold_still_valid", {31'd0, letter_valid}, 32'd1);
        ack_letter("ovf_ack");

        // Single dash, acked in the first HOLD cycle
        base = sv_cnt;
        press(25, 15);
        wait_letter("T_valid");
        chk("T_count", sv_cnt - base, 32'd1);
        chk("T_bit", {31'd0, bits_q[bits_q.size() - 1]}, 32'd1);
        chk("T_len", {29'd0, letter_len}, 32'd1);
        chk("T_err", {31'd0, letter_err}, 32'd0);
        ack_letter("T_ack");

        // Bounce: 3-cycle glitches must not register
        base = sv_cnt;
        for (int i = 0; i < 3; i++) begin
            $display("glitch: key high 3 cycles");
            key_in = 1'b1;
            repeat (3) tick();
            key_in = 1'b0;
            repeat (5) tick();
        end
        repeat (60) tick();
        chk("glitch_no_strobe", sv_cnt - base, 32'd0);
        chk("glitch_no_letter", {31'd0, letter_valid}, 32'd0);

        // Reset in the middle of a press
        base = sv_cnt;
        key_in = 1'b1;
        repeat (30) tick();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("midrst_shift_clr", {31'd0, shift_clr}, 32'd1);
            chk("midrst_outputs", {24'd0, sym_valid, sym_bit, letter_valid, letter_len, letter_err, word_space}, 32'd0);
        end
        rst = 1'b0;
        tick();
        chk("midrst_clr_end", {31'd0, shift_clr}, 32'd0);
        repeat (20) tick();
        key_in = 1'b0;
        repeat (60) tick();
        chk("midrst_no_strobe", sv_cnt - base, 32'd0);
        chk("midrst_no_letter", {31'd0, letter_valid}, 32'd0);

        // Recovery: a normal dot after reset
        press(10, 15);
        wait_letter("E_valid");
        chk("E_count", sv_cnt - base, 32'd1);
        chk("E_bit", {31'd0, bits_q[bits_q.size() - 1]}, 32'd0);
        chk("E_len", {29'd0, letter_len}, 32'd1);
        ack_letter("E_ack");

        // Long idle after an acked letter
        wbase = ws_cnt;
        repeat (300) tick();
`ifdef MORSE_WORD_GAP_EN
        chk("word_space_once", ws_cnt - wbase, 32'd1);
`else
        chk("word_space_off", ws_cnt, 32'd0);
`endif
        chk("never_both_strobes", both_cnt, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
